traffic_sensor_conditioner: RTL and testbench

TRAFFIC_SENSOR_CONDITIONER -- requirements
Module: traffic_sensor_conditioner

---
 rtl/traffic_sensor_conditioner.sv | 135 +++++++++++++
 tb/tb_traffic_sensor_conditioner.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_sensor_conditioner.sv
// Conditions five raw loop detectors: 2-flop sync, debounce, stuck-loop flagging.
// Define SENSOR_CALL_LATCH_EN to hold demand until the channel's light turns green.
module traffic_sensor_conditioner #(
    parameter int unsigned DEB_CYCLES  = 3,
    parameter int unsigned STUCK_LIMIT = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       e_left_raw,
    input  logic       e_str_raw,
    input  logic       w_left_raw,
    input  logic       w_str_raw,
    input  logic       ns_raw,
    input  logic [1:0] e_left_light,
    input  logic [1:0] e_str_light,
    input  logic [1:0] w_left_light,
    input  logic [1:0] w_str_light,
    input  logic [1:0] ns_light,
    output logic       e_left_sensor,
    output logic       e_str_sensor,
    output logic       w_left_sensor,
    output logic       w_str_sensor,
    output logic       ns_sensor,
    output logic [4:0] sensor_fault
);

    localparam int unsigned NumCh    = 5;
    localparam logic [3:0]  DebLast  = 4'(DEB_CYCLES - 1);
    localparam logic [7:0]  StuckMax = 8'(STUCK_LIMIT);
    localparam logic [1:0]  Green    = 2'd2;

    logic [NumCh-1:0]      w_raw;
    logic [NumCh-1:0][1:0] w_light;
    logic [NumCh-1:0]      w_sensor;
    logic [NumCh-1:0]      w_fault;

    assign w_raw   = {ns_raw, w_str_raw, w_left_raw, e_str_raw, e_left_raw};
    assign w_light = {ns_light, w_str_light, w_left_light, e_str_light, e_left_light};

    assign e_left_sensor = w_sensor[0];
    assign e_str_sensor  = w_sensor[1];
    assign w_left_sensor = w_sensor[2];
    assign w_str_sensor  = w_sensor[3];
    assign ns_sensor     = w_sensor[4];
    assign sensor_fault  = w_fault;

`ifndef SENSOR_CALL_LATCH_EN
    logic w_unused_light;
    assign w_unused_light = ^w_light;
`endif

    for (genvar g = 0; g < NumCh; g++) begin : g_ch
        logic       r_sync1;
        logic       r_sync2;
        logic       r_deb;
        logic       w_deb_d;
        logic [3:0] r_deb_cnt;
        logic [3:0] w_deb_cnt_d;
        logic [7:0] r_stuck_cnt;
        logic [7:0] w_stuck_cnt_d;
        logic       r_sensor;
        logic       w_sensor_d;

        // Counter only runs while the synced input disagrees; the final count toggles.
        always_comb begin
            w_deb_d     = r_deb;
            w_deb_cnt_d = 4'd0;
            if (r_sync2 != r_deb) begin
                if (r_deb_cnt == DebLast) begin
                    w_deb_d = ~r_deb;
                end else begin
                    w_deb_cnt_d = r_deb_cnt + 4'd1;
                end
            end
        end

        // Cleared by the next debounced value so the fault drops on the falling edge.
        always_comb begin
            w_stuck_cnt_d = 8'd0;
            if (w_deb_d) begin
                w_stuck_cnt_d = r_stuck_cnt;
                if (r_deb && (r_stuck_cnt != StuckMax)) begin
                    w_stuck_cnt_d = r_stuck_cnt + 8'd1;
                end
            end
        end

`ifdef SENSOR_CALL_LATCH_EN
        logic r_call;
        logic w_call_d;

        // Green clears the call even if the detector rises on the same edge.
        always_comb begin
            w_call_d = r_call | (w_deb_d & ~r_deb);
            if (w_light[g] == Green) begin
                w_call_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_call <= 1'b0;
            end else begin
                r_call <= w_call_d;
            end
        end

        assign w_sensor_d = w_deb_d | w_call_d;
`else
        assign w_sensor_d = w_deb_d;
`endif

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_sync1     <= 1'b0;
                r_sync2     <= 1'b0;
                r_deb       <= 1'b0;
                r_deb_cnt   <= 4'd0;
                r_stuck_cnt <= 8'd0;
                r_sensor    <= 1'b0;
            end else begin
                r_sync1     <= w_raw[g];
                r_sync2     <= r_sync1;
                r_deb       <= w_deb_d;
                r_deb_cnt   <= w_deb_cnt_d;
                r_stuck_cnt <= w_stuck_cnt_d;
                r_sensor    <= w_sensor_d;
            end
        end

        assign w_sensor[g] = r_sensor;
        assign w_fault[g]  = (r_stuck_cnt == StuckMax);
    end

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Self-checking bench for traffic_sensor_conditioner: vector table, directed corner
// sequences and randomized traffic against a sample-history reference model.
module tb_traffic_sensor_conditioner;

    localparam int unsigned DEB = 3;
    localparam int unsigned LIM = 200;
    localparam logic [9:0] AllGreen = 10'b10_10_10_10_10;
    localparam logic [9:0] AllRed   = 10'b00_00_00_00_00;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [4:0]           raw;
    logic [4:0][1:0]      light;
    wire  [4:0]           sens;
    wire  [4:0]           fault;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    traffic_sensor_conditioner #(
        .DEB_CYCLES (DEB),
        .STUCK_LIMIT(LIM)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .e_left_raw   (raw[0]),
        .e_str_raw    (raw[1]),
        .w_left_raw   (raw[2]),
        .w_str_raw    (raw[3]),
        .ns_raw       (raw[4]),
        .e_left_light (light[0]),
        .e_str_light  (light[1]),
        .w_left_light (light[2]),
        .w_str_light  (light[3]),
        .ns_light     (light[4]),
        .e_left_sensor(sens[0]),
        .e_str_sensor (sens[1]),
        .w_left_sensor(sens[2]),
        .w_str_sensor (sens[3]),
        .ns_sensor    (sens[4]),
        .sensor_fault (fault)
    );

    // Reference model: raw samples per edge; a detector changes once the last DEB
    // synchronized samples (two edges old) all disagree with its current state.
    logic [4:0] m_hist[$];
    logic [4:0] m_deb, m_call, m_sens, m_fault;
    int         m_rise[5];
    int         m_k;

    task automatic model_reset();
        m_hist.delete();
        m_deb   = '0;
        m_call  = '0;
        m_sens  = '0;
        m_fault = '0;
        m_k     = 0;
        for (int c = 0; c < 5; c++) m_rise[c] = 0;
    endtask

    function automatic logic hist_bit(input int edge_no, input int c);
        if (edge_no < 1) return 1'b0;
        return m_hist[edge_no-1][c];
    endfunction

    task automatic model_edge();
        logic all_diff;
        logic rose;
        m_hist.push_back(raw);
        m_k++;
        for (int c = 0; c < 5; c++) begin
            all_diff = 1'b1;
            for (int j = 2; j <= int'(DEB) + 1; j++) begin
                if (hist_bit(m_k - j, c) == m_deb[c]) all_diff = 1'b0;
            end
            rose = 1'b0;
            if (all_diff) begin
                m_deb[c] = ~m_deb[c];
                if (m_deb[c]) begin
                    rose      = 1'b1;
                    m_rise[c] = m_k;
                end
            end
            if (light[c] == 2'd2) m_call[c] = 1'b0;
            else if (rose) m_call[c] = 1'b1;
`ifdef SENSOR_CALL_LATCH_EN
            m_sens[c] = m_deb[c] | m_call[c];
`else
            m_sens[c] = m_deb[c];
`endif
            m_fault[c] = m_deb[c] && ((m_k - m_rise[c]) >= int'(LIM));
        end
    endtask

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs, take one rising edge, update the model, sample 1 ns later.
    task automatic step(input logic [4:0] r, input logic [9:0] l);
        raw   = r;
        light = l;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("async_rst_sens", sens, 5'b0);
        check("async_rst_fault", fault, 5'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_sens", sens, 5'b0);
        model_reset();
        reset = 1'b1;
    endtask

    typedef struct {
        logic [4:0] raw;
        logic [4:0] exp_sens;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [4:0] r, input logic [4:0] s);
        vec_t v;
        v.raw      = r;
        v.exp_sens = s;
        tbl.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] lt;
        logic [4:0] exp;
        logic [4:0] r;

        reset = 1'b0;
        raw   = '1;
        light = AllRed;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_sens", sens, 5'b0);
        check("reset_fault", fault, 5'b0);
        reset = 1'b1;

        // All-green lights so behaviour is identical with or without the call latch.
        for (int i = 0; i < 4; i++) add(5'h1F, 5'h00);
        add(5'h1F, 5'h1F);
        for (int i = 0; i < 4; i++) add(5'h00, 5'h1F);
        add(5'h00, 5'h00);
        for (int i = 0; i < 2; i++) add(5'h02, 5'h00);
        for (int i = 0; i < 5; i++) add(5'h00, 5'h00);
        for (int i = 0; i < 3; i++) add(5'h08, 5'h00);
        add(5'h00, 5'h00);
        for (int i = 0; i < 3; i++) add(5'h00, 5'h08);
        add(5'h00, 5'h00);
        foreach (tbl[i]) begin
            step(tbl[i].raw, AllGreen);
            check($sformatf("table[%0d]_sens", i), sens, tbl[i].exp_sens);
            check($sformatf("table[%0d]_fault", i), fault, 5'b0);
        end

        // ns vehicle leaves before service; non-green lights must not clear the call.
        do_reset();
        for (int e = 1; e <= 6; e++) begin
            step(5'b10000, AllRed);
            check($sformatf("ns_rise_e%0d", e), sens, (e >= 5) ? 5'b10000 : 5'b00000);
        end
        for (int e = 7; e <= 16; e++) begin
            lt      = AllRed;
            lt[9:8] = (e % 2 == 1) ? 2'd1 : 2'd3;
            step(5'b00000, lt);
`ifdef SENSOR_CALL_LATCH_EN
            exp = 5'b10000;
`else
            exp = (e <= 10) ? 5'b10000 : 5'b00000;
`endif
            check($sformatf("ns_hold_e%0d", e), sens, exp);
        end
        step(5'b00000, 10'b10_00_00_00_00);
        check("ns_green_clear", sens, 5'b00000);
        step(5'b00000, AllRed);
        check("ns_after_green", sens, 5'b00000);

        // Stuck w_left loop: fault from 200 edges after the debounced rise.
        do_reset();
        for (int e = 1; e <= 258; e++) begin
            r = (e <= 250) ? 5'b00100 : 5'b00000;
            step(r, AllRed);
            check($sformatf("stuck_fault_e%0d", e), fault,
                  (e >= 205 && e <= 254) ? 5'b00100 : 5'b00000);
            if (e < 5) exp = 5'b00000;
            else if (e <= 254) exp = 5'b00100;
            else begin
`ifdef SENSOR_CALL_LATCH_EN
                exp = 5'b00100;
`else
                exp = 5'b00000;
`endif
            end
            check($sformatf("stuck_sens_e%0d", e), sens, exp);
        end

        // Green on the very edge e_left rises: no call is remembered.
        do_reset();
        for (int e = 1; e <= 14; e++) begin
            lt = (e == 5) ? 10'b00_00_00_00_10 : AllRed;
            r  = (e <= 6) ? 5'b00001 : 5'b00000;
            step(r, lt);
            check($sformatf("simul_e%0d", e), sens,
                  (e >= 5 && e <= 10) ? 5'b00001 : 5'b00000);
        end

        // Random traffic with occasional mid-run resets.
        do_reset();
        r  = '0;
        lt = AllRed;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 5; c++) begin
                if ($urandom_range(0, 9) == 0) r[c] = ~r[c];
                if ($urandom_range(0, 7) == 0) lt[2*c +: 2] = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 299) == 0) do_reset();
            step(r, lt);
            check("rand_sens", sens, m_sens);
            check("rand_fault", fault, m_fault);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
